master_port: RTL

Bus-side master port for the serial system bus. Accepts one parallel read/write request from a local requester, serializes address then data MSB-first onto `wr_bus` under the `master_valid`/`slave_ready` handshake, and deserializes the read response from `rd_bus` under `slave_valid`/`master_ready`. Sits directly upstream of the slave port, driving the bus side that the slave consumes.

---
 rtl/system_bus_pkg.sv | 23 ++
 rtl/bus_shift_reg.sv | 39 +++
 rtl/master_port.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/system_bus_pkg.sv
// ============================================================================
// Module  : system_bus_pkg
// Brief   : Shared types and constants for the serial system bus ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package system_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RSP = 3'd2,
    RECV     = 3'd3,
    DONE     = 3'd4
  } master_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bus_shift_reg.sv
// ============================================================================
// Module  : bus_shift_reg
// Brief   : Parallel-load, shift-left register with serial-in and MSB out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             msb
);

  logic [WIDTH-1:0] r_q;

  // Load takes priority so a new frame never mixes with a stale shift.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (shift) begin
      r_q <= {r_q[WIDTH-2:0], serial_in};
    end
  end

  assign q   = r_q;
  assign msb = r_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/master_port.sv
// ============================================================================
// Module  : master_port
// Brief   : Serial system bus master: serializes addr+data MSB-first and
//           deserializes the read response. Define MASTER_PORT_TIMEOUT_EN to
//           enable the stall timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module master_port
  import system_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  input  logic                  rd_bus,
  input  logic                  slave_valid,
  output logic                  master_ready
);

  localparam int c_FRAME_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);

  master_state_t         r_state;
  master_state_t         w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_accept;
  logic                  w_tx_fire;
  logic                  w_rx_fire;
  logic                  w_tx_last;
  logic                  w_rx_last;
  logic                  w_timeout;
  logic [c_FRAME_W-1:0]  w_tx_load_data;
  logic [c_FRAME_W-1:0]  w_tx_q;
  logic                  w_tx_msb;
  logic [DATA_WIDTH-1:0] w_rx_q;
  logic                  w_rx_msb;
  logic                  w_unused;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_tx_fire = (r_state == SEND) && slave_ready;
  assign w_rx_fire = (r_state == RECV) && slave_valid;
  assign w_tx_last = w_tx_fire && (r_cnt == c_CNT_W'(c_FRAME_W - 1));
  assign w_rx_last = w_rx_fire && (r_cnt == c_CNT_W'(DATA_WIDTH - 1));

  // Reads put zeros in the data field regardless of req_wdata.
  assign w_tx_load_data = {req_addr,
                           (req_mode == MODE_WRITE) ? req_wdata : {DATA_WIDTH{1'b0}}};

  bus_shift_reg #(.WIDTH(c_FRAME_W)) u_tx_shift (
    .clk       (clk),
    .rstn      (rstn),
    .load      (w_accept),
    .load_data (w_tx_load_data),
    .shift     (w_tx_fire),
    .serial_in (1'b0),
    .q         (w_tx_q),
    .msb       (w_tx_msb)
  );

  bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx_shift (
    .clk       (clk),
    .rstn      (rstn),
    .load      (w_accept),
    .load_data ({DATA_WIDTH{1'b0}}),
    .shift     (w_rx_fire),
    .serial_in (rd_bus),
    .q         (w_rx_q),
    .msb       (w_rx_msb)
  );

  assign w_unused = ^{w_tx_q, w_rx_msb};

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int c_STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_STALL_W-1:0] r_stall;
  logic                 r_rsp_err;
  logic                 w_stalling;

  assign w_stalling = ((r_state == SEND) && !slave_ready) ||
                      ((r_state == WAIT_RSP) && !slave_valid);
  assign w_timeout  = w_stalling && (r_stall == c_STALL_W'(TIMEOUT_CYCLES - 1));

  // Cleared by any transfer and by every state change.
  always_ff @(posedge clk) begin
    if (!rstn || !w_stalling || (w_state_nxt != r_state)) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp_err <= 1'b0;
    end else if ((w_state_nxt == DONE) && (r_state != DONE)) begin
      r_rsp_err <= w_timeout;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_timeout_unused;

  assign w_timeout_unused = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (req_valid) w_state_nxt = SEND;
      SEND: begin
        if (w_tx_last) begin
          w_state_nxt = (r_mode == MODE_WRITE) ? DONE : WAIT_RSP;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      WAIT_RSP: begin
        if (slave_valid) begin
          w_state_nxt = RECV;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      RECV:     if (w_rx_last) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_mode      <= MODE_READ;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_mode <= req_mode;
      end else if ((r_state == WAIT_RSP) && slave_valid) begin
        r_cnt <= '0;
      end else if (w_tx_fire || w_rx_fire) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // The last bit is captured straight from rd_bus so data is valid in DONE.
      if (w_rx_last) begin
        r_rsp_rdata <= {w_rx_q[DATA_WIDTH-2:0], rd_bus};
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
      end
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign rsp_valid    = (r_state == DONE);
  assign master_valid = (r_state == SEND);
  assign master_ready = (r_state == RECV);
  assign wr_bus       = (r_state == SEND) && w_tx_msb;
  assign mode         = r_mode;
  assign rsp_rdata    = r_rsp_rdata;

endmodule

`default_nettype wire
